// File: rtl/timer_apb_pkg.sv
// Shared state encoding and timer register map for the timer APB arbiter.
package timer_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] TCR   = 32'h0000_0000;
    localparam logic [31:0] TDR0  = 32'h0000_0004;
    localparam logic [31:0] TDR1  = 32'h0000_0008;
    localparam logic [31:0] TCMP0 = 32'h0000_000C;
    localparam logic [31:0] TCMP1 = 32'h0000_0010;
    localparam logic [31:0] TIER  = 32'h0000_0014;
    localparam logic [31:0] TISR  = 32'h0000_0018;

endpackage

// File: rtl/timer_apb_arbiter_rr.sv
// Round-robin grant logic: combinational pick starting after the last owner,
// with a registered last-owner pointer advanced by upd.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic            upd,
    input  logic [IW-1:0]   upd_idx,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_idx
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(NREQ - 1);
        end else if (upd) begin
            last_q <= upd_idx;
        end
    end

    // The last owner is visited last, so it only wins when nobody else asks.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!gnt_valid && req[cand] && !mask[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/timer_apb_arbiter.sv
// Shares the timer APB slave between NREQ req/ack requesters with
// round-robin arbitration and an ACCESS-phase watchdog.
//
// state  | meaning
// IDLE   | no transfer; grant the next unmasked requester
// SETUP  | psel=1, penable=0, transaction latched
// ACCESS | psel=1, penable=1; wait for pready or watchdog expiry
module timer_apb_arbiter
    import timer_apb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [31:0]        rdata,
    output logic               tim_psel,
    output logic               tim_penable,
    output logic               tim_pwrite,
    output logic [31:0]        tim_paddr,
    output logic [31:0]        tim_pwdata,
    input  logic [31:0]        tim_prdata,
    input  logic               tim_pready
);

    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    apb_state_e    state;
    logic [IW-1:0] owner;
    logic [WW-1:0] wdog;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          done;

    // pready is tested first so a reply in the final allowed cycle succeeds.
    assign done = (state == ACCESS) && (tim_pready || (wdog == WD_LAST));

    // Masking with the live ack stops a stale req from being re-granted.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .req       (req),
        .mask      (ack),
        .upd       (done),
        .upd_idx   (owner),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            wdog        <= '0;
            ack         <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= '0;
            tim_pwdata  <= '0;
        end else begin
            ack   <= '0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner       <= gnt_idx;
                        wdog        <= '0;
                        tim_psel    <= 1'b1;
                        tim_penable <= 1'b0;
                        tim_pwrite  <= req_write[gnt_idx];
                        tim_paddr   <= req_addr[32*gnt_idx +: 32];
                        tim_pwdata  <= req_wdata[32*gnt_idx +: 32];
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    tim_penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        tim_psel     <= 1'b0;
                        tim_penable  <= 1'b0;
                        ack[owner]   <= 1'b1;
                        err          <= !tim_pready;
                        rdata        <= (tim_pready && !tim_pwrite) ? tim_prdata : 32'h0;
                        state        <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_apb_arbiter.sv
// Scoreboard bench for timer_apb_arbiter: drivers push expected responses,
// a monitor checks acks, arbitration and APB stability against a request-level model.
`timescale 1ns/1ps
module tb_timer_apb_arbiter;
    import timer_apb_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic               sys_clk     = 1'b0;
    logic               sys_rst_n   = 1'b0;
    logic [NREQ-1:0]    req         = '0;
    logic [NREQ-1:0]    req_write   = '0;
    logic [NREQ*32-1:0] req_addr    = '0;
    logic [NREQ*32-1:0] req_wdata   = '0;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic [31:0]        rdata;
    logic               tim_psel, tim_penable, tim_pwrite;
    logic [31:0]        tim_paddr, tim_pwdata;
    logic [31:0]        tim_prdata  = '0;
    logic               tim_pready  = 1'b0;
    logic [NREQ-1:0]    req_snap    = '0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
    } txn_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc_cycles;
    } resp_t;

    txn_t  cur [NREQ];
    resp_t exp_q [NREQ][$];
    int    vectors = 0;
    int    miscompares = 0;

    timer_apb_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req         (req),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_prdata  (tim_prdata),
        .tim_pready  (tim_pready)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] prdata, input int waits);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.prdata = prdata; t.waits = waits;
        return t;
    endfunction

    // A slave reply in ACCESS cycle waits+1 succeeds only if that is within TIMEOUT cycles.
    function automatic resp_t model(input txn_t t);
        resp_t r;
        r.err        = (t.waits >= TIMEOUT);
        r.acc_cycles = r.err ? TIMEOUT : t.waits + 1;
        r.rdata      = (r.err || t.wr) ? 32'h0 : t.prdata;
        return r;
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic load(input int p, input txn_t t);
        cur[p]              = t;
        req_write[p]        = t.wr;
        req_addr[32*p +: 32]  = t.addr;
        req_wdata[32*p +: 32] = t.wdata;
    endtask

    task automatic expect_resp(input int p);
        exp_q[p].push_back(model(cur[p]));
    endtask

    task automatic do_txn(input int p, input txn_t t, input bit drop_early);
        int n;
        bit seen;
        @(negedge sys_clk);
        load(p, t);
        expect_resp(p);
        req[p] = 1'b1;
        n = 0;
        seen = 0;
        while (n < 400) begin
            @(negedge sys_clk);
            n++;
            if (ack[p]) break;
            if (drop_early && seen) req[p] = 1'b0;
            if (tim_psel && !tim_penable && tim_paddr[31:28] == 4'(p)) seen = 1;
        end
        req[p] = 1'b0;
        check($sformatf("ack_seen_p%0d", p), 32'(ack[p]), 32'd1);
    endtask

    function automatic txn_t rand_txn(input int p);
        int r;
        int w;
        r = $urandom_range(0, 9);
        w = (r < 6) ? r % 4 : (r < 8) ? 0 : (r == 8) ? TIMEOUT - 1 : TIMEOUT;
        return mk(1'($urandom), {4'(p), 20'($urandom), 8'($urandom) & 8'hFC}, $urandom, $urandom, w);
    endfunction

    task automatic rand_drv(input int p);
        repeat (25) begin
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            do_txn(p, rand_txn(p), 1'b0);
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        req_snap = req;
    end

    // Timer slave: wait states and read data come from the owning port's current transaction.
    initial begin
        int   cnt;
        int   p;
        txn_t t;
        cnt = 0;
        forever begin
            @(negedge sys_clk);
            if (tim_psel && tim_penable) begin
                cnt++;
                p = int'(tim_paddr[31:28]);
                if (p >= NREQ) p = 0;
                t = cur[p];
                tim_prdata = t.prdata;
                tim_pready = (t.waits < TIMEOUT) && (cnt == t.waits + 1);
            end else begin
                cnt = 0;
                tim_pready = 1'b0;
                tim_prdata = $urandom;
            end
        end
    end

    // Monitor: scoreboard pops on ack, arbitration model on SETUP, stability in ACCESS.
    initial begin
        int    acc;
        int    last;
        int    own;
        int    w;
        resp_t r;
        acc = 0; last = NREQ - 1; own = -1;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                acc = 0; last = NREQ - 1; own = -1;
                for (int p = 0; p < NREQ; p++) exp_q[p].delete();
            end else begin
                if (ack != '0) begin
                    check("ack_onehot", 32'($onehot(ack)), 32'd1);
                    for (int p = 0; p < NREQ; p++) begin
                        if (ack[p]) begin
                            if (exp_q[p].size() == 0) begin
                                check($sformatf("unexpected_ack_p%0d", p), 32'(ack[p]), 32'd0);
                            end else begin
                                r = exp_q[p].pop_front();
                                check($sformatf("err_p%0d", p), 32'(err), 32'(r.err));
                                check($sformatf("rdata_p%0d", p), rdata, r.rdata);
                                check($sformatf("access_cycles_p%0d", p), 32'(acc), 32'(r.acc_cycles));
                            end
                        end
                    end
                    check("psel_low_on_ack", 32'(tim_psel), 32'd0);
                    acc = 0;
                end
                if (tim_psel && !tim_penable) begin
                    w = rr_pick(last, req_snap);
                    check("grant_port", 32'(tim_paddr[31:28]), 32'(w));
                    own = w;
                    if (w >= 0) last = w;
                end
                if (tim_psel && tim_penable && own >= 0) begin
                    acc++;
                    check("apb_paddr", tim_paddr, cur[own].addr);
                    check("apb_pwrite", 32'(tim_pwrite), 32'(cur[own].wr));
                    check("apb_pwdata", tim_pwdata, cur[own].wdata);
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not complete, got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int got;
        txn_t t;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst_psel", 32'(tim_psel), 32'd0);
        check("rst_penable", 32'(tim_penable), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_paddr", tim_paddr, 32'd0);
        sys_rst_n = 1'b1;

        // Both ports held: strict alternation starting at port 0
        @(negedge sys_clk);
        load(0, mk(1'b0, TDR0, 32'h0, 32'h0000_1111, 0));
        load(1, mk(1'b1, 32'h1000_0004, 32'h2222_0000, 32'h0, 1));
        repeat (2) begin expect_resp(0); expect_resp(1); end
        req = 2'b11;
        got = 0; n = 0;
        while (got < 4 && n < 200) begin
            @(negedge sys_clk);
            n++;
            if (ack != '0) begin
                check("rr_order", 32'(ack), (got % 2 == 0) ? 32'd1 : 32'd2);
                got++;
                if (got == 4) req = '0;
            end
        end
        req = '0;
        check("rr_count", 32'(got), 32'd4);

        // Zero-wait read latency on port 0
        @(negedge sys_clk);
        load(0, mk(1'b0, TCR, 32'h0, 32'h0000_0103, 0));
        expect_resp(0);
        req[0] = 1'b1;
        @(negedge sys_clk);
        check("lat_c1_psel", 32'(tim_psel), 32'd1);
        check("lat_c1_penable", 32'(tim_penable), 32'd0);
        @(negedge sys_clk);
        check("lat_c2_psel", 32'(tim_psel), 32'd1);
        check("lat_c2_penable", 32'(tim_penable), 32'd1);
        @(negedge sys_clk);
        check("lat_c3_ack", 32'(ack), 32'd1);
        check("lat_c3_rdata", rdata, 32'h0000_0103);
        req[0] = 1'b0;

        do_txn(0, mk(1'b1, TIER, 32'hDEAD_BEEF, 32'h1234_5678, 3), 1'b0);
        do_txn(0, mk(1'b0, TDR1, 32'h0, 32'h5555_AAAA, TIMEOUT), 1'b0);
        do_txn(1, mk(1'b0, 32'h1000_0008, 32'h0, 32'h0BAD_F00D, 0), 1'b0);
        do_txn(0, mk(1'b0, TCMP0, 32'h0, 32'hA5A5_5A5A, TIMEOUT - 1), 1'b0);
        do_txn(1, mk(1'b1, 32'h1000_0010, 32'hCAFE_0001, 32'h0, 1), 1'b1);

        // Single port holding req: the ack cycle must not re-grant it
        @(negedge sys_clk);
        load(0, mk(1'b0, TISR, 32'h0, 32'h0000_0077, 0));
        expect_resp(0); expect_resp(0);
        req[0] = 1'b1;
        n = 0;
        while (!ack[0] && n < 50) begin @(negedge sys_clk); n++; end
        check("mask_first_ack", 32'(ack[0]), 32'd1);
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!tim_psel && n < 20);
        check("mask_regrant_gap", 32'(n), 32'd2);
        n = 0;
        while (!ack[0] && n < 50) begin @(negedge sys_clk); n++; end
        req[0] = 1'b0;
        check("mask_second_ack", 32'(ack[0]), 32'd1);

        fork
            rand_drv(0);
            rand_drv(1);
        join

        // Reset in ACCESS: bus drops at once, transaction lost, port 0 wins afterwards
        @(negedge sys_clk);
        load(0, mk(1'b0, TCMP1, 32'h0, 32'h0, TIMEOUT));
        req[0] = 1'b1;
        n = 0;
        while (!tim_penable && n < 20) begin @(negedge sys_clk); n++; end
        check("rst_mid_reached_access", 32'(tim_penable), 32'd1);
        req[0] = 1'b0;
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_mid_psel", 32'(tim_psel), 32'd0);
        check("rst_mid_penable", 32'(tim_penable), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("rst_no_ack", 32'(ack), 32'd0);
        end
        fork
            do_txn(0, mk(1'b0, TCR, 32'h0, 32'h0000_0F0F, 0), 1'b0);
            do_txn(1, mk(1'b0, 32'h1000_0000, 32'h0, 32'h0000_F0F0, 0), 1'b0);
        join

        repeat (4) @(negedge sys_clk);
        for (int p = 0; p < NREQ; p++)
            check($sformatf("queue_empty_p%0d", p), 32'(exp_q[p].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
